fft_peak_detect: RTL and testbench

Consumer of the 16-bin FFT output bus. On each `fft_valid` it snapshots the 16 packed complex bins and scans them sequentially, one bin per clock, computing power as re²+im². It then reports the index of the strongest bin as `freq`, with a one-cycle `done` pulse. It sits directly downstream of the FFT core and drives the `done`/`freq` result interface toward the testbench/host.

---
 rtl/fft_peak_detect.sv | 167 ++++++++++++++++
 tb/tb_fft_peak_detect.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// Peak-bin finder for the 16-bin FFT output bus: snapshots a frame, scans one bin per clock
// computing re^2+im^2, and reports the strongest bin index and its power with a done pulse.
module fft_peak_detect #(
    parameter bit SKIP_DC = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic [31:0] max_pow,
    output logic        overrun
);

    typedef enum logic {StIdle, StScan} state_t;

    state_t             state_q, state_d;
    logic [15:0][31:0]  din;
    logic [15:0][31:0]  w_q, w_d;
    logic [15:0][31:0]  p_q, p_d;
    logic               pend_q, pend_d;
    logic [3:0]         idx_q, idx_d;
    logic [31:0]        best_pow_q, best_pow_d;
    logic [3:0]         best_idx_q, best_idx_d;
    logic               done_q, done_d;
    logic [3:0]         freq_q, freq_d;
    logic [31:0]        max_pow_q, max_pow_d;
    logic               overrun_q, overrun_d;

    logic [31:0]        sel;
    logic signed [15:0] re, im;
    logic signed [31:0] re_sq, im_sq;
    logic [31:0]        pow;
    logic               take;
    logic [31:0]        cand_pow;
    logic [3:0]         cand_idx;
    logic               start;

    assign din = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                  fft_d7, fft_d6, fft_d5, fft_d4, fft_d3, fft_d2, fft_d1, fft_d0};

    // Each square is at most 2^30, so the unsigned sum of two never exceeds 2^31.
    always_comb begin
        sel      = w_q[idx_q];
        re       = $signed(sel[31:16]);
        im       = $signed(sel[15:0]);
        re_sq    = re * re;
        im_sq    = im * im;
        pow      = $unsigned(re_sq) + $unsigned(im_sq);
        take     = (pow > best_pow_q) && !(SKIP_DC && (idx_q == 4'd0));
        cand_pow = take ? pow : best_pow_q;
        cand_idx = take ? idx_q : best_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        p_d        = p_q;
        pend_d     = pend_q;
        idx_d      = idx_q;
        best_pow_d = best_pow_q;
        best_idx_d = best_idx_q;
        done_d     = 1'b0;
        freq_d     = freq_q;
        max_pow_d  = max_pow_q;
        overrun_d  = overrun_q;
        start      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fft_valid) begin
                    w_d     = din;
                    start   = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                best_pow_d = cand_pow;
                best_idx_d = cand_idx;
                idx_d      = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    freq_d    = cand_idx;
                    max_pow_d = cand_pow;
                    done_d    = 1'b1;
                    // A fresh frame on the finish edge beats the pending one.
                    if (fft_valid) begin
                        w_d    = din;
                        start  = 1'b1;
                        pend_d = 1'b0;
                        if (pend_q) begin
                            overrun_d = 1'b1;
                        end
                    end else if (pend_q) begin
                        w_d    = p_q;
                        start  = 1'b1;
                        pend_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (fft_valid) begin
                    p_d    = din;
                    pend_d = 1'b1;
                    if (pend_q) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            idx_d      = 4'd0;
            best_pow_d = 32'd0;
            best_idx_d = SKIP_DC ? 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            w_q        <= '0;
            p_q        <= '0;
            pend_q     <= 1'b0;
            idx_q      <= 4'd0;
            best_pow_q <= 32'd0;
            best_idx_q <= 4'd0;
            done_q     <= 1'b0;
            freq_q     <= 4'd0;
            max_pow_q  <= 32'd0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            p_q        <= p_d;
            pend_q     <= pend_d;
            idx_q      <= idx_d;
            best_pow_q <= best_pow_d;
            best_idx_q <= best_idx_d;
            done_q     <= done_d;
            freq_q     <= freq_d;
            max_pow_q  <= max_pow_d;
            overrun_q  <= overrun_d;
        end
    end

    assign done    = done_q;
    assign freq    = freq_q;
    assign max_pow = max_pow_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: two instances (SKIP_DC 0 and 1) share stimulus; a
// frame-level model predicts which frames get reported, when, and with what peak.
module tb_fft_peak_detect;

    typedef logic [15:0][31:0] frame_t;
    typedef struct {
        int          cyc;
        logic [3:0]  f;
        logic [31:0] p;
    } exp_t;

    localparam int NEVER = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    frame_t      din;
    logic        done0, done1, ovr0, ovr1;
    logic [3:0]  freq0, freq1;
    logic [31:0] pow0, pow1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    // Frame-level model state: is a scan in flight, when it ends, the one-deep waiting slot.
    bit     busy;
    int     fin_edge;
    bit     slot_v;
    frame_t slot;
    int     ov_edge;

    fft_peak_detect #(.SKIP_DC(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
        .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
        .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
        .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
        .done(done0), .freq(freq0), .max_pow(pow0), .overrun(ovr0)
    );

    fft_peak_detect #(.SKIP_DC(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid),
        .fft_d0(din[0]), .fft_d1(din[1]), .fft_d2(din[2]), .fft_d3(din[3]),
        .fft_d4(din[4]), .fft_d5(din[5]), .fft_d6(din[6]), .fft_d7(din[7]),
        .fft_d8(din[8]), .fft_d9(din[9]), .fft_d10(din[10]), .fft_d11(din[11]),
        .fft_d12(din[12]), .fft_d13(din[13]), .fft_d14(din[14]), .fft_d15(din[15]),
        .done(done1), .freq(freq1), .max_pow(pow1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
        end
    endtask

    // Peak = largest power among eligible bins, lowest index on ties; no eligible power -> first
    // eligible bin.
    function automatic void ref_peak(input frame_t fr, input bit skip,
                                     output logic [3:0] f, output logic [31:0] p);
        longint pw[16];
        longint mx = 0;
        int     lo = skip ? 1 : 0;
        int     first = -1;
        for (int k = 0; k < 16; k++) begin
            longint re = longint'($signed(fr[k][31:16]));
            longint im = longint'($signed(fr[k][15:0]));
            pw[k] = re * re + im * im;
        end
        for (int k = lo; k < 16; k++) if (pw[k] > mx) mx = pw[k];
        for (int k = 15; k >= lo; k--) if (pw[k] == mx) first = k;
        f = 4'(first);
        p = mx[31:0];
    endfunction

    task automatic model_start(input frame_t fr, input int e);
        exp_t x;
        x.cyc = e + 16;
        ref_peak(fr, 1'b0, x.f, x.p);
        q0.push_back(x);
        ref_peak(fr, 1'b1, x.f, x.p);
        q1.push_back(x);
        busy     = 1'b1;
        fin_edge = e + 16;
    endtask

    task automatic model_reset();
        busy    = 1'b0;
        slot_v  = 1'b0;
        ov_edge = NEVER;
        q0.delete();
        q1.delete();
    endtask

    // e is the clock edge at which this cycle's inputs are sampled.
    task automatic model_step(input bit v, input frame_t fr);
        int e = cyc + 1;
        if (busy && e == fin_edge) begin
            if (v) begin
                if (slot_v && ov_edge == NEVER) ov_edge = e;
                slot_v = 1'b0;
                model_start(fr, e);
            end else if (slot_v) begin
                slot_v = 1'b0;
                model_start(slot, e);
            end else begin
                busy = 1'b0;
            end
        end else if (busy) begin
            if (v) begin
                if (slot_v && ov_edge == NEVER) ov_edge = e;
                slot   = fr;
                slot_v = 1'b1;
            end
        end else if (v) begin
            model_start(fr, e);
        end
    endtask

    task automatic mon(input int k, input logic dn, input logic [3:0] fq,
                       input logic [31:0] mp, input logic ov);
        exp_t x;
        bit   due = 1'b0;
        chk($sformatf("dc%0d_overrun", k), 32'(ov), 32'(cyc >= ov_edge));
        if (k == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
            due = 1'b1;
            x   = q0.pop_front();
        end else if (k == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
            due = 1'b1;
            x   = q1.pop_front();
        end
        if (due) begin
            chk($sformatf("dc%0d_done", k), 32'(dn), 32'd1);
            chk($sformatf("dc%0d_freq", k), 32'(fq), 32'(x.f));
            chk($sformatf("dc%0d_max_pow", k), mp, x.p);
        end else if (dn) begin
            chk($sformatf("dc%0d_spurious_done", k), 32'(dn), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, done0, freq0, pow0, ovr0);
        mon(1, done1, freq1, pow1, ovr1);
    end

    function automatic logic [31:0] mk(input int re, input int im);
        return {re[15:0], im[15:0]};
    endfunction

    function automatic frame_t fill(input int re, input int im);
        frame_t fr;
        for (int k = 0; k < 16; k++) fr[k] = mk(re, im);
        return fr;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t fr;
        int     mode = int'($urandom_range(0, 2));
        for (int k = 0; k < 16; k++) begin
            if (mode == 0) fr[k] = $urandom;
            else if (mode == 1) fr[k] = mk(int'($urandom_range(0, 6)) - 3,
                                           int'($urandom_range(0, 6)) - 3);
            else fr[k] = 32'd0;
        end
        if (mode == 2) fr[$urandom_range(0, 15)] = $urandom;
        return fr;
    endfunction

    task automatic cycle(input bit v, input frame_t fr);
        @(negedge clk);
        fft_valid = v;
        if (v) din = fr;
        else for (int k = 0; k < 16; k++) din[k] = $urandom;
        model_step(v, fr);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done0"}, 32'(done0), 32'd0);
        chk({tag, "_freq0"}, 32'(freq0), 32'd0);
        chk({tag, "_pow0"}, pow0, 32'd0);
        chk({tag, "_ovr0"}, 32'(ovr0), 32'd0);
        chk({tag, "_done1"}, 32'(done1), 32'd0);
        chk({tag, "_freq1"}, 32'(freq1), 32'd0);
        chk({tag, "_pow1"}, pow1, 32'd0);
        chk({tag, "_ovr1"}, 32'(ovr1), 32'd0);
    endtask

    initial begin
        frame_t fr;
        int     peaks[4] = '{1, 15, 0, 7};
        int     gap;

        rst       = 1'b1;
        fft_valid = 1'b0;
        din       = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single frame with a clear peak at bin 5.
        fr    = fill(16'h0010, 16'h0010);
        fr[5] = mk(16'h0100, 0);
        cycle(1'b1, fr);
        idle(20);

        // Equal power at bins 3 and 11: the lower index must win; signs must not matter.
        fr     = fill(0, 0);
        fr[3]  = mk(-300, 400);
        fr[11] = mk(400, -300);
        cycle(1'b1, fr);
        idle(20);

        // Full-scale negative bin.
        fr    = fill(0, 0);
        fr[9] = mk(-32768, -32768);
        cycle(1'b1, fr);
        idle(20);

        // Back-to-back frames exactly 16 cycles apart.
        for (int i = 0; i < 4; i++) begin
            fr           = fill(1, 1);
            fr[peaks[i]] = mk(100, 0);
            cycle(1'b1, fr);
            idle(15);
        end
        idle(20);

        // Huge DC bin: only the DC-skipping instance should ignore it.
        fr    = fill(0, 0);
        fr[0] = mk(16'h7fff, 16'h7fff);
        fr[2] = mk(1, 0);
        cycle(1'b1, fr);
        idle(20);

        // A, B at +4, C at +8: B is overwritten and overrun latches.
        fr    = fill(0, 0); fr[4]  = mk(50, 0); cycle(1'b1, fr); idle(3);
        fr    = fill(0, 0); fr[8]  = mk(60, 0); cycle(1'b1, fr); idle(3);
        fr    = fill(0, 0); fr[12] = mk(70, 0); cycle(1'b1, fr);
        idle(40);

        // Reset partway through a scan.
        fr    = fill(2, 2);
        fr[6] = mk(-900, 10);
        cycle(1'b1, fr);
        idle(8);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 check_zero("midscan_reset");
        @(negedge clk);
        #2 rst = 1'b0;
        fr     = fill(0, 0);
        fr[13] = mk(3, 4);
        cycle(1'b1, fr);
        idle(20);

        // Random frames with mixed gaps: exact 16-cycle streaming, pending and overrun.
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, rnd_frame());
            case ($urandom_range(0, 3))
                0: gap = 15;
                1: gap = int'($urandom_range(0, 6));
                2: gap = int'($urandom_range(10, 25));
                default: gap = 2;
            endcase
            idle(gap);
        end
        idle(40);

        chk("dc0_outstanding", 32'(q0.size()), 32'd0);
        chk("dc1_outstanding", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
